// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: assembles an opcode byte plus two little-endian operands
// from a byte stream, issues them to the ALU over valid/ready, waits for the
// ALU's done pulse, and holds the result until the host acknowledges it.
// Protocol errors are reported on err_code.
module alu_op_sequencer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_valid,
  input  logic             alu_ready,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  output logic [WIDTH-1:0] res_data,
  output logic [3:0]       res_flags,
  output logic             res_valid,
  input  logic             res_ack,
  output logic             busy,
  output logic [1:0]       err_code
);

  localparam int NB = WIDTH / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] BYTE_LAST = CW'(NB - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_HEADER  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  typedef enum logic [2:0] {
    S_OP, S_LDA, S_LDB, S_ISSUE, S_WAIT, S_OUT
  } state_t;

  state_t        state;
  logic [CW-1:0] byte_cnt;
  logic [TW-1:0] to_cnt;
  logic          overrun;

  // Handshake strobes decode straight from the state register.
  assign alu_valid = (state == S_ISSUE);
  assign res_valid = (state == S_OUT);
  assign busy      = (state != S_OP);

  // A byte arriving while an operation is in flight is dropped and flagged.
  assign overrun = in_valid && (state inside {S_ISSUE, S_WAIT, S_OUT});

  // Sequencer FSM, operand assembly, result capture and error tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_OP;
      byte_cnt  <= '0;
      to_cnt    <= '0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      res_data  <= '0;
      res_flags <= '0;
      err_code  <= ERR_NONE;
    end else begin
      // Overrun is recorded first so a timeout on the same edge wins.
      if (overrun) err_code <= ERR_OVERRUN;

      case (state)
        S_OP: begin
          if (in_valid) begin
            if (in_data[7:4] == 4'h0) begin
              alu_op   <= in_data[3:0];
              err_code <= ERR_NONE;
              byte_cnt <= '0;
              state    <= S_LDA;
            end else begin
              err_code <= ERR_HEADER;
            end
          end
        end

        S_LDA: begin
          if (in_valid) begin
            for (int i = 0; i < NB; i++)
              if (byte_cnt == CW'(i)) alu_a[8*i +: 8] <= in_data;
            if (byte_cnt == BYTE_LAST) begin
              byte_cnt <= '0;
              state    <= S_LDB;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end

        S_LDB: begin
          if (in_valid) begin
            for (int i = 0; i < NB; i++)
              if (byte_cnt == CW'(i)) alu_b[8*i +: 8] <= in_data;
            if (byte_cnt == BYTE_LAST) begin
              byte_cnt <= '0;
              state    <= S_ISSUE;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end

        S_ISSUE: begin
          if (alu_ready) begin
            to_cnt <= '0;
            state  <= S_WAIT;
          end
        end

        // WAIT lasts at most TIMEOUT cycles; done on the final cycle still wins.
        S_WAIT: begin
          if (alu_done) begin
            res_data  <= alu_result;
            res_flags <= alu_flags;
            state     <= S_OUT;
          end else if (to_cnt == TO_LAST) begin
            err_code <= ERR_TIMEOUT;
            state    <= S_OP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        S_OUT: begin
          if (res_ack) state <= S_OP;
        end

        default: state <= S_OP;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: one WIDTH=8 and one WIDTH=16 instance
// share the stimulus; each scenario checks only the instance it targets.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        alu_ready;
  logic        alu_done;
  logic [15:0] alu_result;
  logic [3:0]  alu_flags;
  logic        res_ack;

  logic [3:0]  o8_op,  o16_op;
  logic [7:0]  o8_a,   o8_b,   o8_rd;
  logic [15:0] o16_a,  o16_b,  o16_rd;
  logic        o8_av,  o16_av, o8_rv, o16_rv, o8_busy, o16_busy;
  logic [3:0]  o8_rf,  o16_rf;
  logic [1:0]  o8_err, o16_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(8), .TIMEOUT(16)) u8 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .alu_op(o8_op), .alu_a(o8_a), .alu_b(o8_b), .alu_valid(o8_av),
    .alu_ready(alu_ready), .alu_done(alu_done), .alu_result(alu_result[7:0]),
    .alu_flags(alu_flags), .res_data(o8_rd), .res_flags(o8_rf),
    .res_valid(o8_rv), .res_ack(res_ack), .busy(o8_busy), .err_code(o8_err)
  );

  alu_op_sequencer #(.WIDTH(16), .TIMEOUT(16)) u16 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .alu_op(o16_op), .alu_a(o16_a), .alu_b(o16_b), .alu_valid(o16_av),
    .alu_ready(alu_ready), .alu_done(alu_done), .alu_result(alu_result),
    .alu_flags(alu_flags), .res_data(o16_rd), .res_flags(o16_rf),
    .res_valid(o16_rv), .res_ack(res_ack), .busy(o16_busy), .err_code(o16_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; alu_ready = 1'b0;
    alu_done = 1'b0; alu_result = '0; alu_flags = '0; res_ack = 1'b0;
    do_reset();

    // Reset state
    chk("rst_op",    32'(o8_op), 0);
    chk("rst_a",     32'(o8_a), 0);
    chk("rst_b",     32'(o8_b), 0);
    chk("rst_av",    32'(o8_av), 0);
    chk("rst_rd",    32'(o8_rd), 0);
    chk("rst_rf",    32'(o8_rf), 0);
    chk("rst_rv",    32'(o8_rv), 0);
    chk("rst_busy",  32'(o8_busy), 0);
    chk("rst_err",   32'(o8_err), 0);

    // Basic op with minimum latency
    send(8'h03);
    chk("b_op",   32'(o8_op), 3);
    chk("b_busy", 32'(o8_busy), 1);
    send(8'h25);
    chk("b_a",    32'(o8_a), 32'h25);
    chk("b_av0",  32'(o8_av), 0);
    send(8'h17);
    chk("b_b",    32'(o8_b), 32'h17);
    chk("b_av3",  32'(o8_av), 1);
    alu_ready = 1'b1;
    tick();
    alu_ready = 1'b0;
    chk("b_av4",  32'(o8_av), 0);
    chk("b_rv4",  32'(o8_rv), 0);
    alu_done = 1'b1; alu_result = 16'h003C; alu_flags = 4'h0;
    tick();
    alu_done = 1'b0;
    chk("b_rv5",  32'(o8_rv), 1);
    chk("b_rd",   32'(o8_rd), 32'h3C);
    chk("b_rf",   32'(o8_rf), 0);
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    chk("b_rv6",   32'(o8_rv), 0);
    chk("b_busy6", 32'(o8_busy), 0);

    // Backpressure, then done on the 16th WAIT cycle
    send(8'h01); send(8'hAA); send(8'h55);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("bp_av", 32'(o8_av), 1);
      chk("bp_a",  32'(o8_a), 32'hAA);
    end
    alu_ready = 1'b1;
    tick();
    alu_ready = 1'b0;
    chk("bp_xfer", 32'(o8_av), 0);
    for (int i = 0; i < 15; i++) tick();
    chk("bp_wait15", 32'(o8_busy), 1);
    alu_done = 1'b1; alu_result = 16'h00C3; alu_flags = 4'h9;
    tick();
    alu_done = 1'b0;
    chk("late_rv",  32'(o8_rv), 1);
    chk("late_rd",  32'(o8_rd), 32'hC3);
    chk("late_rf",  32'(o8_rf), 9);
    chk("late_err", 32'(o8_err), 0);
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;

    // Bad header, then recovery
    send(8'h5A);
    chk("hdr_err",  32'(o8_err), 1);
    chk("hdr_busy", 32'(o8_busy), 0);
    send(8'h01);
    chk("hdr_clr",  32'(o8_err), 0);
    chk("hdr_lda",  32'(o8_busy), 1);

    // Timeout: exactly 16 WAIT cycles, then error and idle
    send(8'h11); send(8'h22);
    alu_ready = 1'b1;
    tick();
    alu_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to_busy", 32'(o8_busy), 1);
      chk("to_rv",   32'(o8_rv), 0);
    end
    tick();
    chk("to_err",  32'(o8_err), 2);
    chk("to_busy", 32'(o8_busy), 0);
    chk("to_rv",   32'(o8_rv), 0);

    // Overrun during WAIT, result still delivered
    send(8'h04); send(8'h0F); send(8'hF0);
    alu_ready = 1'b1;
    tick();
    alu_ready = 1'b0;
    send(8'h99);
    chk("ovr_err",  32'(o8_err), 3);
    chk("ovr_a",    32'(o8_a), 32'h0F);
    chk("ovr_busy", 32'(o8_busy), 1);
    alu_done = 1'b1; alu_result = 16'h00FF; alu_flags = 4'h2;
    tick();
    alu_done = 1'b0;
    chk("ovr_rv", 32'(o8_rv), 1);
    chk("ovr_rd", 32'(o8_rd), 32'hFF);
    chk("ovr_rf", 32'(o8_rf), 2);
    // Byte coincident with res_ack is an overrun, not an opcode
    res_ack = 1'b1; in_valid = 1'b1; in_data = 8'h07;
    tick();
    res_ack = 1'b0; in_valid = 1'b0;
    chk("ack_ovr_err",  32'(o8_err), 3);
    chk("ack_ovr_op",   32'(o8_op), 4);
    chk("ack_ovr_busy", 32'(o8_busy), 0);
    chk("ack_rd_hold",  32'(o8_rd), 32'hFF);

    // WIDTH=16 little-endian assembly
    do_reset();
    send(8'h02); send(8'h34); send(8'h12); send(8'hCD); send(8'hAB);
    chk("w16_op", 32'(o16_op), 2);
    chk("w16_a",  32'(o16_a), 32'h1234);
    chk("w16_b",  32'(o16_b), 32'hABCD);
    chk("w16_av", 32'(o16_av), 1);
    alu_ready = 1'b1;
    tick();
    alu_ready = 1'b0;
    alu_done = 1'b1; alu_result = 16'hBEEF; alu_flags = 4'h4;
    tick();
    alu_done = 1'b0;
    chk("w16_rd", 32'(o16_rd), 32'hBEEF);
    chk("w16_rv", 32'(o16_rv), 1);
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;

    // Reset mid-operation clears everything
    send(8'h02); send(8'h34);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_op",   32'(o16_op), 0);
    chk("mr_a",    32'(o16_a), 0);
    chk("mr_b",    32'(o16_b), 0);
    chk("mr_av",   32'(o16_av), 0);
    chk("mr_rd",   32'(o16_rd), 0);
    chk("mr_rf",   32'(o16_rf), 0);
    chk("mr_rv",   32'(o16_rv), 0);
    chk("mr_busy", 32'(o16_busy), 0);
    chk("mr_err",  32'(o16_err), 0);
    send(8'h01); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    chk("nr_a",  32'(o16_a), 32'h2211);
    chk("nr_b",  32'(o16_b), 32'h4433);
    chk("nr_av", 32'(o16_av), 1);
    alu_ready = 1'b1;
    tick();
    alu_ready = 1'b0;
    alu_done = 1'b1; alu_result = 16'h6644; alu_flags = 4'h1;
    tick();
    alu_done = 1'b0;
    chk("nr_rd",  32'(o16_rd), 32'h6644);
    chk("nr_rf",  32'(o16_rf), 1);
    chk("nr_err", 32'(o16_err), 0);
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    chk("nr_busy", 32'(o16_busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command front-end that sits directly upstream of the ALU datapath in `tt_um_alu`. It assembles an opcode and two operands from a byte stream on the dedicated inputs and issues them to the ALU over a valid/ready handshake. It then waits for the ALU's completion and holds the result and flags until the host acknowledges them. It also reports protocol errors: a bad command header, an ALU timeout, or a byte arriving while busy.

## Interface

- `WIDTH`, 8: operand/result width in bits; multiple of 8; operands are WIDTH/8 bytes, little-endian.
- `TIMEOUT`, 16: max cycles spent in WAIT before aborting; ≥ 2.

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high; top level drives it from `~rst_n`.
- `in_data`  in  8  command byte.
- `in_valid`  in  1  `in_data` valid this cycle; one byte per high cycle.
- `alu_op`  out  4  opcode to ALU.
- `alu_a`, `alu_b`  out  WIDTH  operands to ALU.
- `alu_valid`  out  1  operands/opcode valid.
- `alu_ready`  in  1  ALU accepts; transfer when `alu_valid & alu_ready`.
- `alu_done`  in  1  ALU result valid pulse.
- `alu_result`  in  WIDTH  ALU result.
- `alu_flags`  in  4  ALU flags {C,V,N,Z}.
- `res_data`  out  WIDTH  captured result.
- `res_flags`  out  4  captured flags.
- `res_valid`  out  1  result available.
- `res_ack`  in  1  host consumes result.
- `busy`  out  1  high in every state except OP.
- `err_code`  out  2  00 none, 01 bad header, 10 timeout, 11 overrun.

## Operation

- States: OP, LDA, LDB, ISSUE, WAIT, OUT. Reset and power-up state is OP.
- OP, when `in_valid`:
  - If `in_data[7:4]==4'h0`: `alu_op <= in_data[3:0]`, `err_code <= 00`, byte counter cleared, go to LDA.
  - Otherwise: `err_code <= 01`, stay in OP.
- LDA, when `in_valid`: write the byte into `alu_a[8k+7:8k]`, k = byte counter. After byte WIDTH/8−1, clear the counter and go to LDB.
- LDB, when `in_valid`: load `alu_b` the same way. After the last byte, go to ISSUE.
- No `in_valid` in OP/LDA/LDB: state and counter hold indefinitely (no inter-byte timeout).
- ISSUE: `alu_valid=1`. On `alu_ready`, go to WAIT and clear the timeout counter. `alu_a`/`alu_b`/`alu_op` are stable from LDB exit until the next opcode byte.
- WAIT: `alu_done` is sampled only in this state.
  - On `alu_done`: capture `alu_result`→`res_data` and `alu_flags`→`res_flags`, go to OUT.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT: `err_code <= 10`, go to OP. `res_valid` never asserts.
- OUT: `res_valid=1`. On `res_ack`, go to OP. `res_data`/`res_flags` hold until the next capture.
- Overrun: `in_valid` in ISSUE/WAIT/OUT drops the byte and sets `err_code <= 11`. The current operation is not aborted.
- `err_code` holds until overwritten by a later error or cleared by an accepted opcode byte.
- `res_ack` outside OUT, and `alu_ready` outside ISSUE, are ignored.
- Reset mid-operation: next cycle is OP with all outputs at reset values. No partial operands are retained.

## Timing

- Reset values: `alu_op=0`, `alu_a=0`, `alu_b=0`, `alu_valid=0`, `res_data=0`, `res_flags=0`, `res_valid=0`, `busy=0`, `err_code=00`.
- All outputs are registered. `alu_valid`, `res_valid` and `busy` decode directly from the state register.
- A byte is accepted on the edge where `in_valid=1`.
- Minimum latency, WIDTH=8, bytes at cycles 0/1/2:
  - `alu_valid` high in cycle 3.
  - With `alu_ready=1` in cycle 3, WAIT in cycle 4.
  - With `alu_done` in cycle 4, `res_valid` high in cycle 5.
  - With `res_ack` in cycle 5, an opcode byte is accepted in cycle 6.
- A byte with `in_valid` in the same cycle as `res_ack` counts as overrun (state is still OUT).
- `alu_valid` falls the cycle after the handshake edge.
- `res_valid` falls the cycle after the `res_ack` edge.
- Timeout: with no `alu_done`, WAIT lasts exactly TIMEOUT cycles. `err_code=10` and `busy=0` are visible the following cycle.
- `alu_done` arriving in the same cycle the timeout expires takes priority: the result is captured and there is no error.

## Test plan

- Basic op, WIDTH=8: bytes 0x03, 0x25, 0x17, ALU ready immediately, `alu_done` one cycle later with result 0x3C and flags 0x0 → `alu_op=3`, `alu_a=0x25`, `alu_b=0x17`; `res_data=0x3C` with `res_valid` in cycle 5; after `res_ack`, `busy=0` next cycle.
- Backpressure: hold `alu_ready=0` for 7 cycles → `alu_valid` stays high, operands stable, no timeout counting; transfer occurs on the first ready cycle.
- Bad header 0x5A in OP → `err_code=01`, state stays OP; the following 0x01 clears `err_code` to 00 and goes to LDA.
- Timeout, TIMEOUT=16: never assert `alu_done` → 16 cycles in WAIT, then `err_code=10`, `busy=0`, `res_valid` never high. Variant with `alu_done` on the 16th cycle: result is captured and there is no error.
- Overrun: a byte during WAIT → `err_code=11`, the result is still delivered correctly, and the dropped byte does not alter `alu_a`.
- WIDTH=16 plus reset: bytes 0x02, 0x34, 0x12, 0xCD, 0xAB → `alu_a=0x1234`, `alu_b=0xABCD`. Repeat with `rst` asserted after the second byte → all outputs at reset values next cycle; a new command then completes normally.
